// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response encodings plus the
// byte-lane decode and size/alignment legality helpers used by the slaves.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr;
      HSIZE_HALF: lanes = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

  // Size supported and naturally aligned.
  function automatic logic size_align_ok(input logic [2:0] size, input logic [1:0] addr);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr[0];
      HSIZE_WORD: ok = (addr == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_ram_ws_if.sv
// AHB-Lite bus bundle between a master/decoder and the ahb_ram_ws slave.
interface ahb_ram_ws_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_ram_ws_array.sv
// DEPTH_WORDS x 32 storage with a byte-enable synchronous write port and an
// asynchronous read port.
module ahb_ram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          HCLK,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_widx,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_ridx,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:DEPTH_WORDS-1];

  // Per-lane write of the selected word.
  // NOTE: storage has no reset; clearing a RAM would force it into flops and
  // the bus never relies on initial contents.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_widx][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ahb_ram_ws.sv
// AHB-Lite RAM slave with programmable wait states and ERROR response for
// out-of-range, oversize or misaligned transfers.
// Optional feature: define AHB_RAM_WS_STATS_EN to add rd_count/wr_count
// outputs counting completed OKAY reads and writes.
module ahb_ram_ws
  import ahb_pkg::*;
#(
  parameter int MEMWIDTH    = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_ram_ws_if.slave   bus
`ifdef AHB_RAM_WS_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  localparam int IW = MEMWIDTH - 2;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [MEMWIDTH-1:0] DEPTH_L = MEMWIDTH'(DEPTH_WORDS);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_write;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_lanes;
  logic          r_active;   // a legal data phase is in progress
  logic          r_hreadyout;
  logic          r_hresp;

  logic          w_capture;
  logic [IW-1:0] w_idx;
  logic          w_legal;
  logic          w_final;
  logic [3:0]    w_we;
  logic [31:0]   w_mem_rdata;
  logic [31:0]   w_lane_mask;
  logic          w_unused;

  assign w_capture = bus.HREADY & bus.HSEL & bus.HTRANS[1];
  assign w_idx     = bus.HADDR[MEMWIDTH-1:2];
  assign w_legal   = size_align_ok(bus.HSIZE, bus.HADDR[1:0]) &&
                     ({2'b00, w_idx} < DEPTH_L);
  assign w_unused  = &{1'b0, bus.HADDR[31:MEMWIDTH], bus.HTRANS[0]};

  // The final data-phase cycle is the only one in IDLE with a legal transfer pending.
  assign w_final     = r_active & (r_state == S_IDLE);
  assign w_we        = (w_final & r_write) ? r_lanes : 4'b0000;
  assign w_lane_mask = {{8{r_lanes[3]}}, {8{r_lanes[2]}}, {8{r_lanes[1]}}, {8{r_lanes[0]}}};

  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign bus.HRDATA    = (w_final & ~r_write) ? (w_mem_rdata & w_lane_mask) : 32'h0;

  // Transfer FSM: address capture, wait-state count, two-cycle ERROR, registered bus outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_lanes     <= 4'b0000;
      r_active    <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin  // S_IDLE and S_ERR2 both accept an address phase
          r_state     <= S_IDLE;
          r_active    <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          if (w_capture) begin
            r_write <= bus.HWRITE;
            r_idx   <= w_idx[AW-1:0];
            r_lanes <= byte_lanes(bus.HSIZE, bus.HADDR[1:0]);
            if (!w_legal) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else begin
              r_active <= 1'b1;
              if (WAIT_STATES > 0) begin
                r_state     <= S_WAIT;
                r_cnt       <= WS_LOAD;
                r_hreadyout <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  ahb_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .HCLK    (HCLK),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (bus.HWDATA),
    .i_ridx  (r_idx),
    .o_rdata (w_mem_rdata)
  );

`ifdef AHB_RAM_WS_STATS_EN
  // Completed OKAY data-phase counters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (w_final) begin
      if (r_write) wr_count <= wr_count + 32'd1;
      else         rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ahb_ram_ws.md
Name: ahb_ram_ws

Overview:
- AHB-Lite slave RAM; successor to the fixed single-cycle RAM slave.
- Generalised in byte-address width, word depth and programmable wait states.
- Adds an AHB-Lite ERROR response for illegal transfers.
- Sits on the AHB-Lite bus behind the address decoder as general data/program memory.

Parameters:
- MEMWIDTH, 12, byte-address bits decoded (HADDR[MEMWIDTH-1:0]).
- DEPTH_WORDS, 1024, implemented 32-bit words; must be <= 2**(MEMWIDTH-2).
- WAIT_STATES, 0, extra data-phase cycles per OKAY transfer; legal range 0..7.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  reset, asynchronous, active-low
- HSEL  input  1  slave select
- HREADY  input  1  bus ready (previous data phase complete)
- HADDR  input  32  address
- HTRANS  input  2  transfer type
- HWRITE  input  1  1=write
- HSIZE  input  3  transfer size
- HWDATA  input  32  write data (data phase)
- HREADYOUT  output  1  slave ready
- HRESP  output  1  0=OKAY, 1=ERROR
- HRDATA  output  32  read data

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, captured controls cleared. Memory contents are not reset.
- Address capture: when HREADY && HSEL && HTRANS[1] (NONSEQ/SEQ). IDLE and BUSY are ignored and get a zero-wait OKAY.
- Captured fields: write flag, word index HADDR[MEMWIDTH-1:2], byte lanes from HSIZE/HADDR[1:0] (byte->1 lane, halfword->2, word->4).
- Illegal transfer, any of the following, goes to ERROR:
  - word index >= DEPTH_WORDS
  - HSIZE > 3'b010
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]!=0
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
  - Legal capture with WAIT_STATES>0 -> WAIT, counter loaded WAIT_STATES-1.
  - Legal capture with WAIT_STATES=0 -> data phase completes next cycle; FSM stays IDLE.
  - Illegal capture -> ERR1.
- WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 -> IDLE, which is the final data-phase cycle.
- ERR1: HREADYOUT=0, HRESP=1; -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1; -> IDLE, or captures a new address phase if presented (same rules as IDLE).
- OKAY latency: data phase is 1+WAIT_STATES cycles. ERROR latency is always 2 cycles.
- Write: commits on the final data-phase cycle (HREADYOUT=1, HRESP=0), selected lanes only, from HWDATA sampled that edge. No write on ERROR.
- Read: HRDATA is valid combinationally in the final data-phase cycle. Unselected lanes, non-read cycles, WAIT/ERR cycles drive 0.
- Pipelining: a new address phase can be captured in the same cycle a data phase completes. Back-to-back zero-wait transfers run at 1/cycle.
- Read-after-write to the same word in consecutive transfers returns the new data: write commits at the edge ending the write data phase, before the read data phase.
- Reset mid-transfer: abandon, no write, return to reset values immediately.

Optional Feature:
- Macro AHB_RAM_WS_STATS_EN.
- Defined: adds outputs rd_count[31:0] and wr_count[31:0].
  - Each increments by 1 on every completed OKAY read/write data phase; wraps at 2**32.
  - Both reset to 0 on HRESETn. ERROR transfers are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE encodings
  - HRESP OKAY/ERROR constants
  - byte-lane decode function
  - legality-check function (size/alignment)
- Module-local enum for the FSM state.
- One natural sub-module: ahb_ram_array (DEPTH_WORDS x 32 storage, 4-bit byte-enable write port, asynchronous read port).

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF @0x010, then word read @0x010 -> HREADYOUT never low, HRDATA=0xDEADBEEF, HRESP=0.
- WAIT_STATES=3: write 0x12345678 @0x020, then read it -> HREADYOUT low exactly 3 cycles each data phase, data returned on 4th cycle, HRDATA=0 during waits.
- Byte write 0xAA @0x023 over 0x12345678, then halfword read @0x022 -> HRDATA=0xAA340000 (lanes 2-3), lanes 0-1 zero.
- DEPTH_WORDS=1024: read @0x1000 masked to 0x000 vs depth 512 read @0x800 -> ERROR: cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, memory unchanged.
- Misaligned word write @0x002 and HSIZE=3'b011 -> both 2-cycle ERROR, no lanes written; following legal read in ERR2 address phase completes OKAY.
- Assert HRESETn low during WAIT of a write -> HREADYOUT=1, HRESP=0 immediately, target word unchanged; with AHB_RAM_WS_STATS_EN, counts reflect only completed transfers (e.g. 2 reads, 3 writes).
